// File: rtl/color_sensor_emulator_if.sv
// Configuration bus for the colour sensor emulator.
// The master (host/testbench) writes a 16-bit base half-period into one of
// the four filter registers; there is no back-pressure.
//   cfg_we   : write strobe, one register write per clock with it high
//   cfg_sel  : register index, coded like {s2,s3} (00 red, 01 green, 11 blue, 10 clear)
//   cfg_half : base half-period in clk_50 cycles
interface color_sensor_emulator_if;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_half;

  modport master (output cfg_we, cfg_sel, cfg_half);
  modport slave  (input  cfg_we, cfg_sel, cfg_half);
endinterface

// File: rtl/color_sensor_emulator.sv
// Emulates a light-to-frequency colour sensor (TCS3200 style).
// The s0..s3 pins choose output scaling and photodiode filter. The output is
// a 50% duty square wave whose half-period is the programmed base value for
// the selected filter, multiplied by 1, 5 or 50. Each selection change holds
// freq low for SETTLE_CYCLES cycles before the wave restarts.
// Ports:
//   clk_50     : 50 MHz system clock
//   rst_n      : synchronous active-low reset
//   s0, s1     : scaling select (11 x1, 10 x5, 01 x50, 00 power-down), async
//   s2, s3     : filter select (00 red, 01 green, 11 blue, 10 clear), async
//   cfg        : half-period register write bus (slave side)
//   freq       : emulated sensor square wave
//   state      : 0 OFF, 1 SETTLE, 2 RUN
//   edge_count : rising edges of freq since the last selection change, saturating
module color_sensor_emulator #(
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter logic [15:0] DEF_HALF      = 16'd1000
) (
  input  logic                          clk_50,
  input  logic                          rst_n,
  input  logic                          s0,
  input  logic                          s1,
  input  logic                          s2,
  input  logic                          s3,
  color_sensor_emulator_if.slave        cfg,
  output logic                          freq,
  output logic [1:0]                    state,
  output logic [15:0]                   edge_count
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } fsm_e;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  // ---------------------------------------------------------------------------
  // Pin synchronizers; sel_prev is one cycle behind so a change is seen on the
  // cycle after the second synchronizer flop captures it.
  // ---------------------------------------------------------------------------
  logic [3:0] s_meta, sel, sel_prev;
  logic       sel_change;
  logic [1:0] scale, filt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly like the hardware.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      s_meta   <= '0;
      sel      <= '0;
      sel_prev <= '0;
    end else begin
      s_meta   <= {s0, s1, s2, s3};
      sel      <= s_meta;
      sel_prev <= sel;
    end
  end

  assign sel_change = (sel != sel_prev);
  assign scale      = sel[3:2];
  assign filt       = sel[1:0];

  // ---------------------------------------------------------------------------
  // Base half-period registers, indexed directly by the {s2,s3} code.
  // ---------------------------------------------------------------------------
  logic [15:0] base_q [4];

  // NOTE: this small register file is reset on purpose: its contents are
  // architecturally visible (DEF_HALF after reset), unlike a plain data RAM.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) base_q[i] <= DEF_HALF;
    end else if (cfg.cfg_we) begin
      base_q[cfg.cfg_sel] <= cfg.cfg_half;
    end
  end

  // Effective half-period; 22 bits holds 65535*50 without overflow.
  logic [21:0] base_ext, h;

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    base_ext = {6'd0, base_q[filt]};
    h        = '0;
    case (scale)
      2'b11:   h = base_ext;
      2'b10:   h = base_ext * 22'd5;
      2'b01:   h = base_ext * 22'd50;
      default: h = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  fsm_e          state_q, state_d;
  logic [SW-1:0] settle_cnt, settle_d;
  logic          settle_done;
  logic          run_entry, run_active, settle_active;

  assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk_50) begin
    if (!rst_n) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  // Power-down wins over everything; any other selection change (re)starts
  // SETTLE. OFF is only left through a selection change.
  always_comb begin
    state_d = state_q;
    if (scale == 2'b00)
      state_d = ST_OFF;
    else if (sel_change)
      state_d = ST_SETTLE;
    else if (state_q == ST_SETTLE && settle_done)
      state_d = ST_RUN;
  end

  logic freq_q;

  always_comb begin
    state         = state_q;
    freq          = freq_q;
    run_entry     = (state_d == ST_RUN) && (state_q != ST_RUN);
    run_active    = (state_d == ST_RUN) && (state_q == ST_RUN);
    settle_active = (state_d == ST_SETTLE) && (state_q == ST_SETTLE) && !sel_change;
  end

  // ---------------------------------------------------------------------------
  // Half-period counter and output
  // ---------------------------------------------------------------------------
  logic [21:0] cnt_q, cnt_d;
  logic        freq_d, rise;

  always_comb begin
    cnt_d    = '0;
    freq_d   = 1'b0;
    settle_d = '0;
    if (settle_active) settle_d = settle_cnt + SW'(1);
    if (run_entry) begin
      cnt_d = h;
    end else if (run_active) begin
      freq_d = freq_q;
      cnt_d  = cnt_q;
      if (cnt_q == 22'd0) begin
        // Parked by a zero base; picks up a nonzero write on the next cycle.
        cnt_d = h;
      end else if (cnt_q == 22'd1) begin
        // Reload from the live H so a register write applies from this toggle.
        if (h == 22'd0) begin
          freq_d = 1'b0;
          cnt_d  = '0;
        end else begin
          freq_d = ~freq_q;
          cnt_d  = h;
        end
      end else begin
        cnt_d = cnt_q - 22'd1;
      end
    end
  end

  assign rise = freq_d & ~freq_q;

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      freq_q     <= 1'b0;
      settle_cnt <= '0;
      edge_count <= '0;
    end else begin
      cnt_q      <= cnt_d;
      freq_q     <= freq_d;
      settle_cnt <= settle_d;
      if (sel_change)
        edge_count <= '0;
      else if (rise && edge_count != 16'hFFFF)
        edge_count <= edge_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_color_sensor_emulator.sv
// Directed bench for color_sensor_emulator. Expected values are queued when
// a step is set up and popped when the matching observation is taken.
// Inputs are driven and outputs sampled on the falling edge of clk_50.
module tb_color_sensor_emulator;

  logic        clk_50 = 1'b0;
  logic        rst_n;
  logic        s0, s1, s2, s3;
  logic        freq;
  logic [1:0]  state;
  logic [15:0] edge_count;

  color_sensor_emulator_if cfg_if ();

  color_sensor_emulator #(
    .SETTLE_CYCLES (5),
    .DEF_HALF      (16'd1000)
  ) dut (
    .clk_50     (clk_50),
    .rst_n      (rst_n),
    .s0         (s0),
    .s1         (s1),
    .s2         (s2),
    .s3         (s3),
    .cfg        (cfg_if),
    .freq       (freq),
    .state      (state),
    .edge_count (edge_count)
  );

  always #10 clk_50 = ~clk_50;

  int    checks = 0;
  int    errors = 0;
  string exp_tag [$];
  int    exp_val [$];

  task automatic expect_val(input string tag, input int v);
    exp_tag.push_back(tag);
    exp_val.push_back(v);
  endtask

  task automatic check(input logic [31:0] observed);
    string tag;
    int    expv;
    checks++;
    if (exp_val.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_underflow: observed %0d, expected nothing queued", observed);
    end else begin
      tag  = exp_tag.pop_front();
      expv = exp_val.pop_front();
      assert (observed === 32'(expv))
      else begin
        errors++;
        $error("FAIL %s: observed %0d, expected %0d", tag, observed, expv);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic set_pins(input logic [3:0] v);
    {s0, s1, s2, s3} = v;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] half);
    cfg_if.cfg_we   = 1'b1;
    cfg_if.cfg_sel  = sel;
    cfg_if.cfg_half = half;
    @(negedge clk_50);
    cfg_if.cfg_we   = 1'b0;
  endtask

  // Cycles until state matches; returns limit if it never does.
  task automatic count_until_state(input logic [1:0] st, input int limit, output int n);
    n = 0;
    while (state !== st && n < limit) begin
      @(negedge clk_50);
      n++;
    end
  endtask

  // Cycles until freq reaches level v; returns limit if it never does.
  task automatic count_until_freq(input logic v, input int limit, output int n);
    n = 0;
    while (freq !== v && n < limit) begin
      @(negedge clk_50);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, lo;

    rst_n = 1'b0;
    set_pins(4'b0000);
    cfg_if.cfg_we   = 1'b0;
    cfg_if.cfg_sel  = 2'b00;
    cfg_if.cfg_half = 16'd0;
    wait_cycles(3);

    // Reset state
    expect_val("reset_freq", 0);       check(32'(freq));
    expect_val("reset_state", 0);      check(32'(state));
    expect_val("reset_edge_count", 0); check(32'(edge_count));

    rst_n = 1'b1;
    wait_cycles(5);
    expect_val("idle_stays_off", 0);   check(32'(state));

    // x1 scaling, red = 10
    cfg_write(2'b00, 16'd10);
    expect_val("t1_latency", 3);
    set_pins(4'b1100);
    count_until_state(2'd1, 20, n);    check(32'(n));
    expect_val("t1_settle_len", 5);
    count_until_state(2'd2, 20, n);    check(32'(n));
    expect_val("t1_first_rise", 10);
    count_until_freq(1'b1, 40, n);     check(32'(n));
    expect_val("t1_period", 20);
    count_until_freq(1'b0, 40, hi);
    count_until_freq(1'b1, 40, lo);    check(32'(hi + lo));
    wait_cycles(170);
    expect_val("t1_edge_count_200", 10); check(32'(edge_count));

    // x5 scaling, blue = 10, then x50
    cfg_write(2'b11, 16'd10);
    expect_val("t2_latency", 3);
    set_pins(4'b1011);
    count_until_state(2'd1, 20, n);    check(32'(n));
    expect_val("t2_settle_len", 5);
    count_until_state(2'd2, 20, n);    check(32'(n));
    expect_val("t2_first_rise", 50);
    count_until_freq(1'b1, 200, n);    check(32'(n));
    expect_val("t2_period", 100);
    count_until_freq(1'b0, 200, hi);
    count_until_freq(1'b1, 200, lo);   check(32'(hi + lo));

    expect_val("t2b_latency", 3);
    set_pins(4'b0111);
    count_until_state(2'd1, 20, n);    check(32'(n));
    expect_val("t2b_settle_freq", 0);  check(32'(freq));
    expect_val("t2b_edge_clear", 0);   check(32'(edge_count));
    expect_val("t2b_settle_len", 5);
    count_until_state(2'd2, 20, n);    check(32'(n));
    expect_val("t2b_first_rise", 500);
    count_until_freq(1'b1, 2000, n);   check(32'(n));
    expect_val("t2b_period", 1000);
    count_until_freq(1'b0, 2000, hi);
    count_until_freq(1'b1, 2000, lo);  check(32'(hi + lo));

    // Green 4 -> 8 rewritten during the first high half
    cfg_write(2'b01, 16'd4);
    set_pins(4'b1101);
    count_until_state(2'd1, 20, n);
    expect_val("t3_settle_len", 5);
    count_until_state(2'd2, 20, n);    check(32'(n));
    expect_val("t3_first_rise", 4);
    count_until_freq(1'b1, 40, n);     check(32'(n));
    expect_val("t3_current_half", 4);
    cfg_write(2'b01, 16'd8);
    count_until_freq(1'b0, 40, hi);    check(32'(hi + 1));
    expect_val("t3_next_low", 8);
    count_until_freq(1'b1, 40, lo);    check(32'(lo));
    expect_val("t3_next_high", 8);
    count_until_freq(1'b0, 40, hi);    check(32'(hi));

    // Power-down and restore
    expect_val("t4_off_latency", 3);
    set_pins(4'b0001);
    count_until_state(2'd0, 20, n);    check(32'(n));
    expect_val("t4_off_freq", 0);      check(32'(freq));
    expect_val("t4_restore_latency", 3);
    set_pins(4'b1101);
    count_until_state(2'd1, 20, n);    check(32'(n));
    expect_val("t4_restore_settle", 5);
    count_until_state(2'd2, 20, n);    check(32'(n));

    // Clear = 0 holds freq low, then clear = 3
    cfg_write(2'b10, 16'd0);
    set_pins(4'b1110);
    count_until_state(2'd1, 20, n);
    expect_val("t5_settle_len", 5);
    count_until_state(2'd2, 20, n);    check(32'(n));
    expect_val("t5_zero_no_rise", 200);
    count_until_freq(1'b1, 200, n);    check(32'(n));
    expect_val("t5_zero_edges", 0);    check(32'(edge_count));
    cfg_write(2'b10, 16'd3);
    expect_val("t5_starts", 1);
    count_until_freq(1'b1, 20, n);     check(32'(n < 20));
    expect_val("t5_high", 3);
    count_until_freq(1'b0, 20, hi);    check(32'(hi));
    expect_val("t5_low", 3);
    count_until_freq(1'b1, 20, lo);    check(32'(lo));

    // Reset while freq = 1, with a write and a selection change pending
    expect_val("t6_pre_freq", 1);      check(32'(freq));
    rst_n = 1'b0;
    set_pins(4'b1100);
    cfg_write(2'b00, 16'd7);
    expect_val("t6_freq", 0);          check(32'(freq));
    expect_val("t6_state", 0);         check(32'(state));
    expect_val("t6_edge_count", 0);    check(32'(edge_count));
    rst_n = 1'b1;
    count_until_state(2'd2, 50, n);
    expect_val("t6_red_default", 1000);
    count_until_freq(1'b1, 1100, n);   check(32'(n));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/color_sensor_emulator.md
COLOR_SENSOR_EMULATOR -- requirements
Module: color_sensor_emulator

Interface
REQ-001 Parameter SETTLE_CYCLES, default 5: cycles freq is held low after any selection change.
REQ-002 Parameter DEF_HALF, default 16'd1000: reset value of all four half-period registers.
REQ-003 clk_50  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 s0, s1  input  1 each  frequency-scaling select; asynchronous to the emulator.
REQ-006 s2, s3  input  1 each  photodiode filter select; asynchronous to the emulator.
REQ-007 cfg_we  input  1  write strobe for a half-period register.
REQ-008 cfg_sel  input  2  register index, coded the same as {s2,s3}.
REQ-009 cfg_half  input  16  base half-period in clk_50 cycles.
REQ-010 freq  output  1  emulated sensor square-wave output.
REQ-011 state  output  2  0=OFF, 1=SETTLE, 2=RUN.
REQ-012 edge_count  output  16  rising edges of freq since the last selection change; saturating.

Function
REQ-013 Inputs s0..s3 shall each pass through a 2-flop synchronizer; only synchronized values (sel = {s0,s1,s2,s3}) are used internally.
REQ-014 Filter mapping of {s2,s3}: 00 red, 01 green, 11 blue, 10 clear; each has one 16-bit base half-period register.
REQ-015 Scaling of {s0,s1}: 11 -> H = base; 10 -> H = base*5; 01 -> H = base*50; 00 -> power-down.
REQ-016 H shall be computed at 22 bits, no overflow (65535*50 = 3,276,750).
REQ-017 cfg_we=1 shall write cfg_half into the register at cfg_sel on that clock edge; no back-pressure.
REQ-018 A write to the active register shall not disturb the current half-period; the new H applies from the next freq toggle.
REQ-019 FSM OFF: freq=0, counter cleared; entered whenever synchronized {s0,s1}=00, from any state, on the next edge.
REQ-020 FSM SETTLE: freq=0; counts SETTLE_CYCLES cycles, then enters RUN with the half-period counter loaded to H.
REQ-021 FSM RUN: counter decrements each cycle; at count 1 freq toggles and the counter reloads with the current H.
REQ-022 In RUN, freq therefore has period 2*H cycles and a 50% duty; the first rising edge occurs H cycles after RUN entry.
REQ-023 Any change in the synchronized sel value shall force SETTLE on the next edge (from RUN or SETTLE, which restarts), or OFF if {s0,s1}=00.
REQ-024 The same selection change shall clear edge_count to 0.
REQ-025 In RUN, an active base value of 0 shall hold freq low with no toggling; a later nonzero write takes effect within one cycle.
REQ-026 edge_count shall increment on each 0->1 transition of freq and saturate at 16'hFFFF.
REQ-027 A cfg write coinciding with a selection change shall complete; the SETTLE exit then uses the newly written value.
REQ-028 Latency, s-pin change to state=SETTLE: 3 clk_50 edges (2 synchronizer edges plus 1 FSM edge).

Reset
REQ-029 With rst_n=0 sampled at a clock edge: freq=0, state=OFF, edge_count=0, synchronizers=0, all base registers=DEF_HALF, counter=0.
REQ-030 On release, the FSM shall leave OFF only through REQ-023 and only after a synchronized sel with {s0,s1}!=00 is seen.
REQ-031 Reset asserted mid-RUN shall take effect on the next edge, overriding any pending write or selection change.

Verification
REQ-032 Reset; s0s1=11, s2s3=00, red=10 -> SETTLE 5 cycles, then freq period 20 cycles; edge_count=10 after 200 RUN cycles.
REQ-033 s0s1=10, blue=10 -> period 100 cycles; switch to 01 -> freq low for SETTLE, period 1000, edge_count reset to 0.
REQ-034 In RUN with green=4, write green=8 mid-half-period -> current half stays 4 cycles, following halves are 8 cycles.
REQ-035 s0s1 -> 00 during RUN -> state=OFF and freq=0 within 3 edges; restore 11 -> SETTLE then RUN.
REQ-036 Write clear=0, select 10 -> freq stays 0 indefinitely; write clear=3 -> toggling at period 6 starts.
REQ-037 Pulse rst_n low mid-RUN with freq=1 -> next edge freq=0, state=OFF, registers=1000, edge_count=0.
